// File: rtl/kvz_param_load_ctrl_if.sv
// Bus bundle for kvz_param_load_ctrl: Avalon-MM slave side plus the parameter-word
// valid/ready stream toward the accelerator.
interface kvz_param_load_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [DATA_W-1:0] param_data;
  logic              param_valid;
  logic              param_ready;
  logic              param_last;

  modport slave (
    input  address, chipselect, write_n, writedata, param_ready,
    output readdata, irq, param_data, param_valid, param_last
  );

  modport master (
    output address, chipselect, write_n, writedata, param_ready,
    input  readdata, irq, param_data, param_valid, param_last
  );
endinterface

// File: rtl/kvz_param_load_ctrl.sv
// Parameter-load sequencer for the Kvazaar accelerator: CPU fills a small FIFO, START
// streams it out, then the block waits for the loaded level and reports done/timeout.
module kvz_param_load_ctrl #(
  parameter int          DATA_W          = 32,
  parameter int          DEPTH           = 8,
  parameter logic [15:0] TIMEOUT_DEFAULT = 16'd1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  loaded_in,
  kvz_param_load_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_MASK    = 3'd2;
  localparam logic [2:0] A_DATA    = 3'd3;
  localparam logic [2:0] A_TIMEOUT = 3'd4;
  localparam logic [2:0] A_COUNT   = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t             state;
  logic               valid_q;
  logic [15:0]        timer;
  logic [15:0]        count;
  logic [15:0]        timeout_reg;
  logic [2:0]         irq_mask;
  logic               done_flag;
  logic               timeout_flag;
  logic               ovf_flag;
  logic [31:0]        readdata_q;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [LVL_W-1:0]   level;

  logic               sync1, sync2, sync_d;

  // Bus decode and datapath strobes
  logic        wr, wr_ctrl, wr_data, wr_status;
  logic        start, abort;
  logic        fifo_full, push, drop, hs, last_word;
  logic        loaded_edge, done_set, timeout_set;
  logic [2:0]  w1c;
  logic [31:0] status_word;

  always_comb begin
    wr          = bus.chipselect & ~bus.write_n;
    wr_ctrl     = wr && (bus.address == A_CTRL);
    wr_data     = wr && (bus.address == A_DATA);
    wr_status   = wr && (bus.address == A_STATUS);
    abort       = wr_ctrl & bus.writedata[1];
    start       = wr_ctrl & bus.writedata[0] & ~bus.writedata[1];
    fifo_full   = (level == LVL_W'(DEPTH));
    push        = wr_data && (state == IDLE) && !fifo_full;
    drop        = wr_data && !push;
    last_word   = (level == LVL_W'(1));
    hs          = valid_q & bus.param_ready;
    loaded_edge = sync2 & ~sync_d;
    done_set    = (state == WAIT) && loaded_edge && !abort;
    timeout_set = (state == WAIT) && !loaded_edge && (timer == 16'd1) && !abort;
    w1c         = wr_status ? bus.writedata[3:1] : 3'b000;
  end

  // NOTE: every always_comb output gets a full default first so no latch can form.
  always_comb begin
    status_word              = '0;
    status_word[0]           = (state != IDLE);
    status_word[1]           = done_flag;
    status_word[2]           = timeout_flag;
    status_word[3]           = ovf_flag;
    status_word[8 +: LVL_W]  = level;
  end

  // NOTE: loaded_in is asynchronous to clk; two flops settle it before edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= loaded_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // NOTE: the FIFO storage is not reset; pointers and level define what is valid,
  // and param_data is gated by valid so stale contents never reach the port.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.writedata[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (abort) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      level  <= level + LVL_W'(1);
    end else if (hs) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
      level  <= level - LVL_W'(1);
    end
  end

  // Sequencer: states, stream valid, timer and transfer count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      timer   <= '0;
      count   <= '0;
    end else if (abort) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (level != '0)) begin
            state   <= SEND;
            valid_q <= 1'b1;
            count   <= '0;
          end
        end
        SEND: begin
          if (hs) begin
            count <= count + 16'd1;
            if (last_word) begin
              state   <= WAIT;
              valid_q <= 1'b0;
              timer   <= timeout_reg;
            end
          end
        end
        WAIT: begin
          if (done_set || timeout_set) begin
            state <= IDLE;
          end else if (timer != 16'd0) begin
            timer <= timer - 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky status: a hardware set in the same cycle as a W1C keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      ovf_flag     <= 1'b0;
      irq_mask     <= '0;
      timeout_reg  <= TIMEOUT_DEFAULT;
    end else begin
      done_flag    <= (done_flag    & ~w1c[0]) | done_set;
      timeout_flag <= (timeout_flag & ~w1c[1]) | timeout_set;
      ovf_flag     <= (ovf_flag     & ~w1c[2]) | drop;
      if (wr && (bus.address == A_MASK))    irq_mask    <= bus.writedata[2:0];
      if (wr && (bus.address == A_TIMEOUT)) timeout_reg <= bus.writedata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      case (bus.address)
        A_CTRL:    readdata_q <= {30'd0, state};
        A_STATUS:  readdata_q <= status_word;
        A_MASK:    readdata_q <= {29'd0, irq_mask};
        A_TIMEOUT: readdata_q <= {16'd0, timeout_reg};
        A_COUNT:   readdata_q <= {16'd0, count};
        default:   readdata_q <= '0;
      endcase
    end
  end

  assign bus.readdata    = readdata_q;
  assign bus.irq         = |({ovf_flag, timeout_flag, done_flag} & irq_mask);
  assign bus.param_valid = valid_q;
  assign bus.param_last  = valid_q & last_word;
  assign bus.param_data  = valid_q ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_kvz_param_load_ctrl.sv
// Randomized bench for kvz_param_load_ctrl against a transfer-level model: word queue,
// expected emission order, and outcome time derived from timeout and loaded delay.
module tb_kvz_param_load_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_MASK    = 3'd2;
  localparam logic [2:0] A_DATA    = 3'd3;
  localparam logic [2:0] A_TIMEOUT = 3'd4;
  localparam logic [2:0] A_COUNT   = 3'd5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic loaded_in = 1'b0;

  kvz_param_load_ctrl_if #(.DATA_W(DATA_W)) bus ();

  kvz_param_load_ctrl #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .TIMEOUT_DEFAULT(16'd1000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .loaded_in(loaded_in),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  // One complete transfer: n pushes, START, random ready, loaded raised d cycles after
  // the last handshake. Outcome edge index: loaded edge lands 3 cycles after it is driven.
  task automatic run_transfer(input int n, input int tmo, input int d, input logic [2:0] mask);
    logic [31:0] q[$];
    logic [31:0] w, rd;
    int          exp_cnt, out, cyc;
    bit          exp_ovf, is_to;
    logic        exp_bit;

    bus_write(A_TIMEOUT, 32'(tmo));
    bus_write(A_MASK, {29'd0, mask});
    exp_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (q.size() < DEPTH) q.push_back(w);
      else exp_ovf = 1'b1;
      bus_write(A_DATA, w);
    end
    exp_cnt = q.size();
    bus_read(A_STATUS, rd);
    check("pre_status", rd, (32'(exp_cnt) << 8) | (exp_ovf ? 32'h8 : 32'h0));
    bus_write(A_STATUS, 32'hE);
    check("pre_irq", {31'd0, bus.irq}, 32'd0);

    bus_write(A_CTRL, 32'h1);
    cyc = 0;
    while (q.size() > 0 && cyc < 500) begin
      bus.param_ready = ($urandom_range(0, 2) != 0);
      check("valid", {31'd0, bus.param_valid}, 32'd1);
      check("data", bus.param_data, q[0]);
      check("last", {31'd0, bus.param_last}, (q.size() == 1) ? 32'd1 : 32'd0);
      if (bus.param_ready) void'(q.pop_front());
      @(negedge clk);
      cyc++;
    end
    bus.param_ready = 1'b0;
    if (q.size() != 0) begin
      check("send_budget", 32'(q.size()), 32'd0);
      return;
    end

    is_to   = (tmo != 0) && (d + 3 > tmo);
    out     = is_to ? tmo : d + 3;
    exp_bit = is_to ? mask[1] : mask[0];
    for (int j = 0; j <= out + 1; j++) begin
      check("irq_wait", {31'd0, bus.irq}, (j >= out) ? {31'd0, exp_bit} : 32'd0);
      if (j == d) loaded_in = 1'b1;
      @(negedge clk);
    end
    check("valid_after", {31'd0, bus.param_valid}, 32'd0);

    bus_read(A_CTRL, rd);
    check("post_state", rd, 32'd0);
    bus_read(A_STATUS, rd);
    check("post_status", rd, is_to ? 32'h4 : 32'h2);
    bus_read(A_COUNT, rd);
    check("count", rd, 32'(exp_cnt));

    loaded_in = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(A_STATUS, 32'hE);
    check("cleared_irq", {31'd0, bus.irq}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          tmo;

    bus.address     = '0;
    bus.chipselect  = 1'b0;
    bus.write_n     = 1'b1;
    bus.writedata   = '0;
    bus.param_ready = 1'b0;

    // Reset values
    #1;
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    check("rst_valid", {31'd0, bus.param_valid}, 32'd0);
    check("rst_last", {31'd0, bus.param_last}, 32'd0);
    check("rst_data", bus.param_data, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(A_TIMEOUT, rd);
    check("rst_timeout", rd, 32'd1000);
    bus_read(A_CTRL, rd);
    check("rst_state", rd, 32'd0);
    bus_read(A_STATUS, rd);
    check("rst_status", rd, 32'd0);
    bus_read(A_MASK, rd);
    check("rst_mask", rd, 32'd0);

    // Directed transfers: done with mask bit0, exact timeout, masked-off irq,
    // overflow on DEPTH+1 pushes, and edge coinciding with expiry.
    run_transfer(3, 0, 2, 3'b001);
    run_transfer(1, 20, 40, 3'b010);
    run_transfer(2, 30, 5, 3'b000);
    run_transfer(DEPTH + 1, 50, 3, 3'b111);
    run_transfer(2, 10, 7, 3'b011);
    run_transfer(1, 1, 0, 3'b111);

    for (int t = 0; t < 25; t++) begin
      tmo = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
      run_transfer(int'($urandom_range(1, DEPTH + 2)), tmo,
                   int'($urandom_range(0, 35)), 3'($urandom_range(0, 7)));
    end

    // DATA write during SEND, then ABORT (with START) after one of four words
    for (int i = 0; i < 4; i++) bus_write(A_DATA, 32'h100 + 32'(i));
    bus_write(A_CTRL, 32'h1);
    check("ab_valid", {31'd0, bus.param_valid}, 32'd1);
    check("ab_data0", bus.param_data, 32'h100);
    bus.param_ready = 1'b1;
    @(negedge clk);
    bus.param_ready = 1'b0;
    check("ab_data1", bus.param_data, 32'h101);
    bus_write(A_DATA, 32'hDEAD);
    bus_read(A_STATUS, rd);
    check("send_ovf_status", rd, 32'h0309);
    bus_write(A_CTRL, 32'h3);
    check("ab_valid_drop", {31'd0, bus.param_valid}, 32'd0);
    bus_read(A_CTRL, rd);
    check("ab_state", rd, 32'd0);
    bus_read(A_STATUS, rd);
    check("ab_status", rd, 32'h8);
    bus_write(A_STATUS, 32'hE);
    bus_write(A_CTRL, 32'h1);
    check("empty_start_valid", {31'd0, bus.param_valid}, 32'd0);
    bus_read(A_CTRL, rd);
    check("empty_start_state", rd, 32'd0);

    // Reset pulse while waiting indefinitely
    bus_write(A_TIMEOUT, 32'd0);
    bus_write(A_MASK, 32'h7);
    bus_write(A_DATA, 32'h55);
    bus_write(A_CTRL, 32'h1);
    bus.param_ready = 1'b1;
    @(negedge clk);
    bus.param_ready = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(A_CTRL, rd);
    check("wait_state", rd, 32'd2);
    bus_write(A_DATA, 32'h77);
    check("wait_ovf_irq", {31'd0, bus.irq}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_irq", {31'd0, bus.irq}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.param_valid}, 32'd0);
    check("mid_rst_readdata", bus.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(A_TIMEOUT, rd);
    check("mid_rst_timeout", rd, 32'd1000);
    bus_read(A_STATUS, rd);
    check("mid_rst_status", rd, 32'd0);
    bus_read(A_CTRL, rd);
    check("mid_rst_state", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
